fir_tdm_mac_filter: RTL and testbench

//  Parametrised FIR filter: N-tap delay line, run-time coefficient register file and NUM_MAC parallel

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_mac_lane.sv | 26 ++
 rtl/fir_tdm_mac_filter.sv | 132 +++++++++++++
 tb/tb_fir_tdm_mac_filter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: FSM states, 4-PAM codes and arithmetic helpers for the TDM FIR filter
package fir_pkg;
    typedef enum logic [1:0] {IDLE, MAC, DONE, UPDATE} state_e;
    localparam logic [2:0] PAM_P1 = 3'b001;
    localparam logic [2:0] PAM_P3 = 3'b011;
    localparam logic [2:0] PAM_M1 = 3'b111;
    localparam logic [2:0] PAM_M3 = 3'b101;
    function automatic logic signed [2:0] pam_decode(input logic [2:0] code);
        return code == PAM_P1 ? 3'sd1 :
               code == PAM_P3 ? 3'sd3 :
               code == PAM_M1 ? -3'sd1 :
               code == PAM_M3 ? -3'sd3 : 3'sd0;
    endfunction
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction
endpackage

// File: rtl/fir_mac_lane.sv
// fir_mac_lane: selects tap cyc*NUM_MAC+LANE and forms its full-precision coefficient*sample product
module fir_mac_lane
    import fir_pkg::*;
#(
    parameter int NUM_TAPS = 33,
    parameter int NUM_MAC  = 2,
    parameter int LANE     = 0,
    parameter int XW       = 3,
    parameter int COEF_W   = 16,
    parameter int CW       = 5,
    parameter int TAP_AW   = 6
)(
    input  logic [CW-1:0]               cyc,
    input  logic signed [COEF_W-1:0]    coef [NUM_TAPS],
    input  logic signed [XW-1:0]        x [NUM_TAPS],
    output logic signed [COEF_W+XW-1:0] prod
);
    localparam int PW = COEF_W + XW;
    logic [31:0] t;
    logic [TAP_AW-1:0] idx;
    always_comb begin
        t = 32'(cyc) * NUM_MAC + LANE;
        idx = t[TAP_AW-1:0];
        prod = t < NUM_TAPS ? PW'(coef[idx]) * PW'(x[idx]) : '0;
    end
endmodule

// File: rtl/fir_tdm_mac_filter.sv
// fir_tdm_mac_filter: time-multiplexed FIR with run-time coefficients, rounding, saturation and overrun flag
module fir_tdm_mac_filter
    import fir_pkg::*;
#(
    parameter int NUM_TAPS = 33,
    parameter int NUM_MAC  = 2,
    parameter int DIN_W    = 3,
    parameter int PAM_MODE = 1,
    parameter int COEF_W   = 16,
    parameter int ACC_W    = 36,
    parameter int SHIFT    = 0,
    parameter int DOUT_W   = 16,
    parameter int TAP_AW   = $clog2(NUM_TAPS)
)(
    input  logic                     iClk12M,
    input  logic                     iRst,
    input  logic                     iEnSample,
    input  logic                     iCoeffUpdateFlag,
    input  logic                     iCoeffWe,
    input  logic [TAP_AW-1:0]        iCoeffAddr,
    input  logic signed [COEF_W-1:0] iCoeffData,
    input  logic [DIN_W-1:0]         iFirIn,
    output logic signed [DOUT_W-1:0] oFirOut,
    output logic                     oFirValid,
    output logic                     oBusy,
    output logic                     oOverrun,
    output logic                     oSatFlag
);
    localparam int NC  = (NUM_TAPS + NUM_MAC - 1) / NUM_MAC;
    localparam int CW  = NC > 1 ? $clog2(NC) : 1;
    localparam int XW  = DIN_W > 3 ? DIN_W : 3;
    localparam int PW  = COEF_W + XW;
    localparam int RND = (1 << SHIFT) >> 1;
    state_e state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, lane_sum, rounded;
    logic signed [XW-1:0] x_q [NUM_TAPS], x_d [NUM_TAPS];
    logic signed [COEF_W-1:0] coef_q [NUM_TAPS], coef_d [NUM_TAPS];
    logic signed [DOUT_W-1:0] out_q, out_d;
    logic valid_q, valid_d, sat_q, sat_d, ovr_q, ovr_d;
    logic signed [PW-1:0] prod [NUM_MAC];
    logic signed [63:0] y_full, y_sat;
    logic signed [XW-1:0] sample;
    logic busy;
    for (genvar l = 0; l < NUM_MAC; l++) begin : g_lane
        fir_mac_lane #(
            .NUM_TAPS(NUM_TAPS), .NUM_MAC(NUM_MAC), .LANE(l), .XW(XW),
            .COEF_W(COEF_W), .CW(CW), .TAP_AW(TAP_AW)
        ) u_lane (.cyc(cyc_q), .coef(coef_q), .x(x_q), .prod(prod[l]));
    end
    assign sample  = PAM_MODE != 0 ? XW'(pam_decode(iFirIn[2:0])) : XW'($signed(iFirIn));
    assign busy    = state_q == MAC || state_q == DONE;
    assign rounded = (acc_q + ACC_W'(RND)) >>> SHIFT;
    assign y_full  = 64'(rounded);
    assign y_sat   = saturate(y_full, DOUT_W);
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < NUM_MAC; l++) lane_sum = lane_sum + ACC_W'(prod[l]);
    end
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        acc_d   = acc_q;
        x_d     = x_q;
        coef_d  = coef_q;
        out_d   = out_q;
        valid_d = 1'b0;
        sat_d   = 1'b0;
        ovr_d   = ovr_q | (iEnSample & busy);
        case (state_q)
            IDLE: begin
                if (iCoeffUpdateFlag) state_d = UPDATE;
                else if (iEnSample) begin
                    x_d[0] = sample;
                    for (int k = 1; k < NUM_TAPS; k++) x_d[k] = x_q[k-1];
                    acc_d   = '0;
                    cyc_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d   = acc_q + lane_sum;
                cyc_d   = cyc_q + CW'(1);
                state_d = cyc_q == CW'(NC - 1) ? DONE : MAC;
            end
            DONE: begin
                out_d   = DOUT_W'(y_sat);
                valid_d = 1'b1;
                sat_d   = y_sat != y_full;
                state_d = iCoeffUpdateFlag ? UPDATE : IDLE;
            end
            UPDATE: begin
                if (iCoeffWe && 32'(iCoeffAddr) < NUM_TAPS) coef_d[iCoeffAddr] = iCoeffData;
                state_d = iCoeffUpdateFlag ? UPDATE : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // entering UPDATE flushes stale samples and acknowledges any overrun
        if (state_d == UPDATE && state_q != UPDATE) begin
            x_d   = '{default: '0};
            ovr_d = 1'b0;
        end
    end
    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            acc_q   <= '0;
            x_q     <= '{default: '0};
            coef_q  <= '{default: '0};
            out_q   <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            coef_q  <= coef_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
            ovr_q   <= ovr_d;
        end
    end
    assign oFirOut   = out_q;
    assign oFirValid = valid_q;
    assign oBusy     = busy;
    assign oOverrun  = ovr_q;
    assign oSatFlag  = sat_q;
endmodule

// File: tb/tb_fir_tdm_mac_filter.sv
// tb_fir_tdm_mac_filter: random and directed stimulus checked against an arithmetic FIR reference model
module tb_fir_tdm_mac_filter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_sample = 1'b0, upd_flag = 1'b0, coef_we = 1'b0;
    logic [5:0] coef_addr = '0;
    logic signed [15:0] coef_data = '0;
    logic [2:0] fir_in = '0;
    logic signed [15:0] fir_out;
    logic fir_valid, busy, overrun, sat_flag;
    int n_chk = 0, n_err = 0;
    int mc [33];
    int hx [33];
    int cset [33];
    int last_out;
    int kaiser_half [17] = '{3, 0, -6, 7, -2, -12, 19, -6, -25, 42, -14, -50, 93, -37, -120, 206, 500};

    fir_tdm_mac_filter dut (
        .iClk12M(clk), .iRst(rst), .iEnSample(en_sample), .iCoeffUpdateFlag(upd_flag),
        .iCoeffWe(coef_we), .iCoeffAddr(coef_addr), .iCoeffData(coef_data), .iFirIn(fir_in),
        .oFirOut(fir_out), .oFirValid(fir_valid), .oBusy(busy), .oOverrun(overrun), .oSatFlag(sat_flag)
    );

    always #41 clk = ~clk;

    initial begin
        #(82 * 60000);
        $display("FAIL watchdog: simulation did not finish within 60000 clocks");
        $fatal(1);
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int pam(input logic [2:0] c);
        case (c)
            3'b001: return 1;
            3'b011: return 3;
            3'b111: return -1;
            3'b101: return -3;
            default: return 0;
        endcase
    endfunction

    function automatic void push(input int v);
        for (int k = 32; k > 0; k--) hx[k] = hx[k-1];
        hx[0] = v;
    endfunction

    function automatic longint model_sum();
        longint s;
        s = 0;
        for (int k = 0; k < 33; k++) s += longint'(mc[k]) * longint'(hx[k]);
        return s;
    endfunction

    task automatic await_result(input string tag, input int start_cycle);
        longint s, e;
        int cyc;
        s = model_sum();
        e = s > 32767 ? 32767 : (s < -32768 ? -32768 : s);
        cyc = start_cycle;
        while (!fir_valid && cyc < 60) begin
            tick();
            cyc++;
        end
        chk({tag, " latency"}, cyc, 19);
        chk({tag, " out"}, fir_out, e);
        chk({tag, " sat"}, sat_flag, e != s ? 1 : 0);
        last_out = fir_out;
        tick();
    endtask

    task automatic send_code(input string tag, input logic [2:0] code);
        en_sample = 1'b1;
        fir_in = code;
        tick();
        en_sample = 1'b0;
        push(pam(code));
        await_result(tag, 1);
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic enter_update();
        upd_flag = 1'b1;
        tick();
        hx = '{default: 0};
    endtask

    task automatic leave_update();
        upd_flag = 1'b0;
        tick();
    endtask

    task automatic set_coef(input int a, input int d);
        coef_we = 1'b1;
        coef_addr = 6'(a);
        coef_data = 16'(d);
        tick();
        coef_we = 1'b0;
        if (a < 33) mc[a] = d;
    endtask

    task automatic load_cset();
        enter_update();
        for (int k = 0; k < 33; k++) set_coef(k, cset[k]);
        leave_update();
    endtask

    initial begin
        int cyc, vcount;
        mc = '{default: 0};
        hx = '{default: 0};
        repeat (3) tick();
        chk("reset out", fir_out, 0);
        chk("reset valid", fir_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset overrun", overrun, 0);
        chk("reset sat", sat_flag, 0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 33; k++) cset[k] = kaiser_half[k < 17 ? k : 32 - k];
        load_cset();
        send_code("kaiser[0]", 3'b001);
        chk("kaiser first", last_out, 3);
        for (int i = 1; i < 34; i++) begin
            send_code($sformatf("kaiser[%0d]", i), 3'b000);
            if (i == 16) chk("kaiser centre", last_out, 500);
        end
        chk("kaiser flushed", last_out, 0);

        cset = '{default: 1};
        load_cset();
        for (int i = 0; i < 33; i++) send_code($sformatf("ones_p3[%0d]", i), 3'b011);
        chk("ones steady +3", last_out, 99);
        for (int i = 0; i < 33; i++) send_code($sformatf("ones_m3[%0d]", i), 3'b101);
        chk("ones steady -3", last_out, -99);
        for (int i = 0; i < 33; i++) send_code($sformatf("ones_inv[%0d]", i), 3'b010);
        chk("ones invalid code", last_out, 0);

        cset = '{default: 32767};
        load_cset();
        for (int i = 0; i < 34; i++) send_code($sformatf("sat_p[%0d]", i), 3'b011);
        chk("sat high out", last_out, 32767);
        chk("sat high flag", sat_flag, 0);
        for (int i = 0; i < 33; i++) send_code($sformatf("sat_n[%0d]", i), 3'b101);
        chk("sat low out", last_out, -32768);

        for (int k = 0; k < 33; k++) cset[k] = int'($urandom_range(0, 1400)) - 700;
        load_cset();
        for (int i = 0; i < 60; i++) send_code($sformatf("rand[%0d]", i), 3'($urandom_range(0, 7)));

        chk("overrun idle", overrun, 0);
        en_sample = 1'b1;
        fir_in = 3'b011;
        tick();
        en_sample = 1'b0;
        push(3);
        cyc = 1;
        repeat (9) begin tick(); cyc++; end
        chk("overrun before", overrun, 0);
        en_sample = 1'b1;
        fir_in = 3'b101;
        tick();
        cyc++;
        en_sample = 1'b0;
        chk("overrun set", overrun, 1);
        await_result("overrun first", cyc);
        send_code("overrun next", 3'b111);
        chk("overrun sticky", overrun, 1);

        en_sample = 1'b1;
        fir_in = 3'b001;
        tick();
        en_sample = 1'b0;
        push(1);
        cyc = 1;
        repeat (5) begin tick(); cyc++; end
        upd_flag = 1'b1;
        await_result("update old coefs", cyc);
        hx = '{default: 0};
        chk("update clears overrun", overrun, 0);
        chk("update not busy", busy, 0);
        set_coef(40, 1234);
        set_coef(0, 77);
        en_sample = 1'b1;
        fir_in = 3'b001;
        tick();
        en_sample = 1'b0;
        vcount = 0;
        repeat (25) begin
            if (fir_valid) vcount++;
            tick();
        end
        chk("update strobe ignored", vcount, 0);
        leave_update();
        send_code("after update", 3'b001);
        chk("after update value", last_out, 77);

        en_sample = 1'b1;
        fir_in = 3'b011;
        tick();
        en_sample = 1'b0;
        repeat (3) tick();
        en_sample = 1'b1;
        tick();
        en_sample = 1'b0;
        chk("mid busy", busy, 1);
        chk("mid overrun", overrun, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid reset out", fir_out, 0);
        chk("mid reset valid", fir_valid, 0);
        chk("mid reset busy", busy, 0);
        chk("mid reset overrun", overrun, 0);
        chk("mid reset sat", sat_flag, 0);
        mc = '{default: 0};
        hx = '{default: 0};
        send_code("post reset", 3'b011);
        chk("post reset zero coefs", last_out, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
